// File: rtl/seg7_pattern_encoder.sv
// Active-low seven-segment pattern to hex encoder: synchronises and debounces the
// segment lines, classifies each newly stable pattern and offers legal digits over valid/ready.
module seg7_pattern_encoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    output logic [3:0] number,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       blank,
    output logic       overrun
);

    localparam int unsigned CW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]  PAT_BLANK = 7'h7F;

    typedef enum logic {EMPTY, FULL} state_t;

    logic [6:0]    s1_q, s2_q, last_q, acc_pat_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          hit;
    logic [3:0]    code;
    logic          legal;

    state_t        state_q;
    logic [3:0]    number_q;
    logic          valid_q, err_q, blank_q, overrun_q;

    // acc_d fires only on the edge the counter first reaches STABLE_CYCLES
    always_comb begin
        cnt_d = cnt_q;
        acc_d = 1'b0;
        if (s1_q != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = (cnt_q == CW'(STABLE_CYCLES - 1)) && (s2_q != last_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= PAT_BLANK;
            s2_q      <= PAT_BLANK;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            acc_pat_q <= PAT_BLANK;
            last_q    <= PAT_BLANK;
        end else begin
            s1_q  <= segments;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            if (acc_d) begin
                acc_pat_q <= s2_q;
                last_q    <= s2_q;
            end
        end
    end

    always_comb begin
        hit  = 1'b1;
        code = '0;
        case (acc_pat_q)
            7'h40: code = 4'h0;
            7'h79: code = 4'h1;
            7'h24: code = 4'h2;
            7'h30: code = 4'h3;
            7'h19: code = 4'h4;
            7'h12: code = 4'h5;
            7'h02: code = 4'h6;
            7'h78: code = 4'h7;
            7'h00: code = 4'h8;
            7'h10: code = 4'h9;
            7'h08: code = 4'hA;
            7'h03: code = 4'hB;
            7'h46: code = 4'hC;
            7'h21: code = 4'hD;
            7'h06: code = 4'hE;
            7'h0E: code = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    assign legal = acc_q && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            number_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            blank_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            err_q <= acc_q && !hit && (acc_pat_q != PAT_BLANK);
            if (acc_q) begin
                blank_q <= (acc_pat_q == PAT_BLANK);
            end
            case (state_q)
                EMPTY: begin
                    if (legal) begin
                        state_q  <= FULL;
                        valid_q  <= 1'b1;
                        number_q <= code;
                    end
                end
                FULL: begin
                    // a simultaneous consume and reload is not an overrun
                    if (legal) begin
                        number_q <= code;
                        if (!out_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign number    = number_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign blank     = blank_q;
    assign overrun   = overrun_q;

endmodule
